// File: rtl/sync_query_pipe_if.sv
// Bundles the capture-FIFO, homography-engine and DVI-side signals of sync_query_pipe.
// The slave modport is the controller's view; the master modport is the environment's view.
interface sync_query_pipe_if #(
    parameter int XW    = 10,
    parameter int CW    = 8,
    parameter int DEPTH = 4
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [2*XW+3*CW-1:0] q;
    logic                 rdempty;
    logic                 rdclk;
    logic                 rdreq;
    logic [XW-1:0]        query_x;
    logic [XW-1:0]        query_y;
    logic                 start;
    logic [XW-1:0]        return_x;
    logic [XW-1:0]        return_y;
    logic [4:0]           r;
    logic [5:0]           g;
    logic [4:0]           b;
    logic                 ready;
    logic [XW-1:0]        sync_x;
    logic [XW-1:0]        sync_y;
    logic [4:0]           dvi_r;
    logic [5:0]           dvi_g;
    logic [4:0]           dvi_b;
    logic                 out_valid;
    logic                 err_mismatch;
    logic                 err_timeout;
    logic [OW-1:0]        outstanding;

    modport slave (
        input  q, rdempty, return_x, return_y, r, g, b, ready,
        output rdclk, rdreq, query_x, query_y, start, sync_x, sync_y,
               dvi_r, dvi_g, dvi_b, out_valid, err_mismatch, err_timeout, outstanding
    );

    modport master (
        output q, rdempty, return_x, return_y, r, g, b, ready,
        input  rdclk, rdreq, query_x, query_y, start, sync_x, sync_y,
               dvi_r, dvi_g, dvi_b, out_valid, err_mismatch, err_timeout, outstanding
    );
endinterface

// File: rtl/sync_query_pipe.sv
// Pixel-sync controller: drains FIFO records, issues engine queries, matches responses in order.
// Optional macro SYNC_FALLBACK_EN republishes the head entry on mismatch/timeout pops.
module sync_query_pipe #(
    parameter int XW     = 10,
    parameter int CW     = 8,
    parameter int DEPTH  = 4,
    parameter int TO_CYC = 255
) (
    input  logic             clk_25,
    input  logic             rst_n,
    sync_query_pipe_if.slave bus
);
    localparam int QW  = 2*XW + 3*CW;
    localparam int PW  = $clog2(DEPTH);
    localparam int CNW = $clog2(DEPTH + 1);
    localparam int DW  = CNW + 1;
    localparam int TW  = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [DW-1:0] DEPTH_L = DW'(DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    function automatic logic [15:0] rgb565(input logic [QW-1:0] rec);
        return {rec[3*CW-1 -: 5], rec[2*CW-1 -: 6], rec[CW-1 -: 5]};
    endfunction

    logic            init_r, rdreq_r, rd_valid_r, start_r;
    logic [XW-1:0]   query_x_r, query_y_r, sync_x_r, sync_y_r;
    logic [4:0]      dvi_r_r, dvi_b_r;
    logic [5:0]      dvi_g_r;
    logic            out_valid_r, err_mismatch_r, err_timeout_r;
    logic [CNW-1:0]  count_r;
    logic [PW-1:0]   head_r, tail_r;
    logic [TW-1:0]   to_cnt_r;
    logic [XW-1:0]   mem_x_r [DEPTH];
    logic [XW-1:0]   mem_y_r [DEPTH];
`ifdef SYNC_FALLBACK_EN
    logic [15:0]     mem_rgb_r [DEPTH];
`endif

    logic [XW-1:0]   head_x_s, head_y_s, rec_x_s, rec_y_s;
    logic [DW-1:0]   demand_s;
    logic            nonempty_s, hit_s, push_s, pop_s;
    logic            match_s, miss_s, spur_s, tmo_s, fb_s, rd_ok_s;
    logic            unused_q_s;

    // The colour bits below the RGB565 truncation are intentionally dropped.
    assign unused_q_s = ^bus.q;
    assign rec_x_s    = bus.q[QW-1 -: XW];
    assign rec_y_s    = bus.q[3*CW +: XW];

    // Return/timeout arbitration and FIFO read admission
    always_comb begin
        head_x_s   = mem_x_r[head_r];
        head_y_s   = mem_y_r[head_r];
        nonempty_s = (count_r != '0);
        hit_s      = (bus.return_x == head_x_s) && (bus.return_y == head_y_s);
        push_s     = rd_valid_r;
        pop_s      = 1'b0;
        match_s    = 1'b0;
        miss_s     = 1'b0;
        spur_s     = 1'b0;
        tmo_s      = 1'b0;
        if (bus.ready) begin
            if (nonempty_s) begin
                pop_s = 1'b1;
                if (hit_s) begin
                    match_s = 1'b1;
                end else begin
                    miss_s = 1'b1;
                end
            end else begin
                spur_s = 1'b1;
            end
        end else if (nonempty_s && (to_cnt_r == TO_LAST)) begin
            pop_s = 1'b1;
            tmo_s = 1'b1;
        end else begin
            tmo_s = 1'b0;
        end
`ifdef SYNC_FALLBACK_EN
        fb_s = miss_s | tmo_s;
`else
        fb_s = 1'b0;
`endif
        // Reserve a slot for every read whose record has not been pushed yet.
        demand_s = {1'b0, count_r} + DW'(rdreq_r) + DW'(rd_valid_r);
        rd_ok_s  = init_r && !bus.rdempty && (demand_s < DEPTH_L);
    end

    // Issue path, tag queue pointers/count and registered return outputs
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            init_r         <= 1'b0;
            rdreq_r        <= 1'b0;
            rd_valid_r     <= 1'b0;
            start_r        <= 1'b0;
            query_x_r      <= '0;
            query_y_r      <= '0;
            sync_x_r       <= '0;
            sync_y_r       <= '0;
            dvi_r_r        <= 5'd0;
            dvi_g_r        <= 6'd0;
            dvi_b_r        <= 5'd0;
            out_valid_r    <= 1'b0;
            err_mismatch_r <= 1'b0;
            err_timeout_r  <= 1'b0;
            count_r        <= '0;
            head_r         <= '0;
            tail_r         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_x_r[i] <= '0;
                mem_y_r[i] <= '0;
            end
        end else begin
            init_r         <= 1'b1;
            rdreq_r        <= rd_ok_s;
            rd_valid_r     <= rdreq_r;
            start_r        <= push_s;
            out_valid_r    <= match_s | fb_s;
            err_mismatch_r <= miss_s | spur_s;
            err_timeout_r  <= tmo_s;
            if (push_s) begin
                mem_x_r[tail_r] <= rec_x_s;
                mem_y_r[tail_r] <= rec_y_s;
                tail_r          <= tail_r + PW'(1);
                query_x_r       <= rec_x_s;
                query_y_r       <= rec_y_s;
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNW'(1);
                2'b01:   count_r <= count_r - CNW'(1);
                default: count_r <= count_r;
            endcase
            if (match_s) begin
                sync_x_r <= bus.return_x;
                sync_y_r <= bus.return_y;
                dvi_r_r  <= bus.r;
                dvi_g_r  <= bus.g;
                dvi_b_r  <= bus.b;
            end
`ifdef SYNC_FALLBACK_EN
            else if (fb_s) begin
                sync_x_r                     <= head_x_s;
                sync_y_r                     <= head_y_s;
                {dvi_r_r, dvi_g_r, dvi_b_r}  <= mem_rgb_r[head_r];
            end
`endif
        end
    end

    // Head-of-queue age counter; restarts for each new head
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= '0;
        end else if (pop_s || !nonempty_s) begin
            to_cnt_r <= '0;
        end else if (!bus.ready) begin
            to_cnt_r <= to_cnt_r + TW'(1);
        end
    end

`ifdef SYNC_FALLBACK_EN
    // Colour copy of each queued record, republished when its query fails
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_rgb_r[i] <= 16'd0;
            end
        end else if (push_s) begin
            mem_rgb_r[tail_r] <= rgb565(bus.q);
        end
    end
`endif

    assign bus.rdclk        = clk_25;
    assign bus.rdreq        = rdreq_r;
    assign bus.query_x      = query_x_r;
    assign bus.query_y      = query_y_r;
    assign bus.start        = start_r;
    assign bus.sync_x       = sync_x_r;
    assign bus.sync_y       = sync_y_r;
    assign bus.dvi_r        = dvi_r_r;
    assign bus.dvi_g        = dvi_g_r;
    assign bus.dvi_b        = dvi_b_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.err_mismatch = err_mismatch_r;
    assign bus.err_timeout  = err_timeout_r;
    assign bus.outstanding  = count_r;
endmodule

// File: tb/tb_sync_query_pipe.sv
// Directed bench for sync_query_pipe with a small capture-FIFO model and hand-computed expectations.
module tb_sync_query_pipe;
    localparam int XW = 10, CW = 8, DEPTH = 4, TO_CYC = 255;
    localparam int QW = 2*XW + 3*CW;

    logic clk_25 = 1'b0;
    logic rst_n  = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    sync_query_pipe_if #(.XW(XW), .CW(CW), .DEPTH(DEPTH)) bus ();
    sync_query_pipe #(.XW(XW), .CW(CW), .DEPTH(DEPTH), .TO_CYC(TO_CYC)) dut (
        .clk_25 (clk_25),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #20 clk_25 = ~clk_25;

    // Capture FIFO model; its empty flag already accounts for a read accepted this cycle.
    logic [QW-1:0] fifo_mem [16];
    int fifo_wr = 0;
    int fifo_rd = 0;
    assign bus.rdempty = ((fifo_wr - fifo_rd) <= (bus.rdreq ? 1 : 0));
    always @(posedge clk_25) begin
        if (bus.rdreq) begin
            bus.q   <= fifo_mem[fifo_rd % 16];
            fifo_rd <= fifo_rd + 1;
        end
    end

    task automatic push_rec(input int x, input int y, input logic [7:0] rr, gg, bb);
        fifo_mem[fifo_wr % 16] = {XW'(x), XW'(y), rr, gg, bb};
        fifo_wr = fifo_wr + 1;
    endtask

    task automatic drive_ready(input int x, input int y, input int rr, input int gg, input int bb);
        bus.return_x = XW'(x);
        bus.return_y = XW'(y);
        bus.r        = 5'(rr);
        bus.g        = 6'(gg);
        bus.b        = 5'(bb);
        bus.ready    = 1'b1;
    endtask

    task automatic test_reset();
        logic [72:0] all_out;
        rst_n = 1'b0;
        drive_ready(0, 0, 0, 0, 0);
        bus.ready = 1'b0;
        repeat (3) @(negedge clk_25);
        all_out = {bus.rdreq, bus.start, bus.query_x, bus.query_y, bus.sync_x, bus.sync_y,
                   bus.dvi_r, bus.dvi_g, bus.dvi_b, bus.out_valid, bus.err_mismatch,
                   bus.err_timeout, bus.outstanding};
        n_vec++;
        if (all_out !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        n_vec++;
        if (bus.rdclk !== clk_25) begin n_err++; $display("FAIL rdclk: got %b want %b", bus.rdclk, clk_25); end
        push_rec(5, 7, 8'hF8, 8'hFC, 8'hF8);
        rst_n = 1'b1;
        @(negedge clk_25);
        n_vec++;
        if (bus.rdreq !== 1'b0) begin n_err++; $display("FAIL reset_holdoff: rdreq got %b want 0", bus.rdreq); end
    endtask

    task automatic test_single();
        int cyc = 0;
        while (bus.rdreq !== 1'b1 && cyc < 10) begin @(negedge clk_25); cyc++; end
        n_vec++;
        if (bus.rdreq !== 1'b1) begin n_err++; $display("FAIL single_rdreq: no rdreq within %0d cycles", cyc); end
        @(negedge clk_25);
        n_vec++;
        if ({bus.rdreq, bus.start} !== 2'b00) begin n_err++; $display("FAIL single_n1: rdreq/start got %b want 00", {bus.rdreq, bus.start}); end
        @(negedge clk_25);
        n_vec++;
        if ({bus.start, bus.query_x, bus.query_y} !== {1'b1, 10'd5, 10'd7}) begin
            n_err++; $display("FAIL single_start: got start=%b x=%0d y=%0d want 1/5/7", bus.start, bus.query_x, bus.query_y);
        end
        n_vec++;
        if (bus.outstanding !== 3'd1) begin n_err++; $display("FAIL single_outstanding: got %0d want 1", bus.outstanding); end
        @(negedge clk_25);
        n_vec++;
        if (bus.start !== 1'b0) begin n_err++; $display("FAIL single_start_pulse: got %b want 0", bus.start); end
        drive_ready(5, 7, 3, 9, 4);
        @(negedge clk_25);
        bus.ready = 1'b0;
        n_vec++;
        if ({bus.out_valid, bus.err_mismatch, bus.sync_x, bus.sync_y, bus.dvi_r, bus.dvi_g, bus.dvi_b, bus.outstanding}
            !== {1'b1, 1'b0, 10'd5, 10'd7, 5'd3, 6'd9, 5'd4, 3'd0}) begin
            n_err++; $display("FAIL single_return: got v=%b e=%b sync=(%0d,%0d) dvi=(%0d,%0d,%0d) occ=%0d want 1 0 (5,7) (3,9,4) 0",
                bus.out_valid, bus.err_mismatch, bus.sync_x, bus.sync_y, bus.dvi_r, bus.dvi_g, bus.dvi_b, bus.outstanding);
        end
        @(negedge clk_25);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_pulse: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_fill();
        int pulses = 0;
        for (int i = 0; i < 6; i++) push_rec(10 + i, 20 + i, 8'h88, 8'h44, 8'hC8);
        repeat (12) begin
            @(negedge clk_25);
            if (bus.rdreq === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 4) begin n_err++; $display("FAIL fill_pulses: got %0d want 4", pulses); end
        n_vec++;
        if (bus.outstanding !== 3'd4) begin n_err++; $display("FAIL fill_outstanding: got %0d want 4", bus.outstanding); end
        n_vec++;
        if ({bus.rdreq, bus.query_x, bus.query_y} !== {1'b0, 10'd13, 10'd23}) begin
            n_err++; $display("FAIL fill_hold: got rdreq=%b q=(%0d,%0d) want 0 (13,23)", bus.rdreq, bus.query_x, bus.query_y);
        end
    endtask

    task automatic test_mismatch();
        drive_ready(11, 20, 1, 2, 3);
        @(negedge clk_25);
        bus.ready = 1'b0;
        n_vec++;
        if ({bus.err_mismatch, bus.outstanding} !== {1'b1, 3'd3}) begin
            n_err++; $display("FAIL mismatch_flag: got err=%b occ=%0d want 1 3", bus.err_mismatch, bus.outstanding);
        end
        n_vec++;
`ifdef SYNC_FALLBACK_EN
        if ({bus.out_valid, bus.sync_x, bus.sync_y, bus.dvi_r, bus.dvi_g, bus.dvi_b}
            !== {1'b1, 10'd10, 10'd20, 5'h11, 6'h11, 5'h19}) begin
            n_err++; $display("FAIL mismatch_fallback: got v=%b sync=(%0d,%0d) dvi=(%0d,%0d,%0d) want 1 (10,20) (17,17,25)",
                bus.out_valid, bus.sync_x, bus.sync_y, bus.dvi_r, bus.dvi_g, bus.dvi_b);
        end
`else
        if ({bus.out_valid, bus.sync_x, bus.sync_y, bus.dvi_r, bus.dvi_g, bus.dvi_b}
            !== {1'b0, 10'd5, 10'd7, 5'd3, 6'd9, 5'd4}) begin
            n_err++; $display("FAIL mismatch_hold: got v=%b sync=(%0d,%0d) dvi=(%0d,%0d,%0d) want 0 (5,7) (3,9,4)",
                bus.out_valid, bus.sync_x, bus.sync_y, bus.dvi_r, bus.dvi_g, bus.dvi_b);
        end
`endif
        @(negedge clk_25);
        n_vec++;
        if ({bus.rdreq, bus.err_mismatch} !== 2'b10) begin
            n_err++; $display("FAIL mismatch_resume: got rdreq=%b err=%b want 1 0", bus.rdreq, bus.err_mismatch);
        end
    endtask

    task automatic test_back_to_back();
        logic [XW-1:0] ex, ey;
        for (int i = 0; i < 4; i++) begin
            drive_ready(11 + i, 21 + i, i + 1, i + 8, i + 16);
            ex = XW'(11 + i);
            ey = XW'(21 + i);
            @(negedge clk_25);
            n_vec++;
            if ({bus.out_valid, bus.err_mismatch, bus.sync_x, bus.sync_y, bus.dvi_r, bus.dvi_g, bus.dvi_b}
                !== {1'b1, 1'b0, ex, ey, 5'(i + 1), 6'(i + 8), 5'(i + 16)}) begin
                n_err++; $display("FAIL b2b_%0d: got v=%b e=%b sync=(%0d,%0d) dvi=(%0d,%0d,%0d) want 1 0 (%0d,%0d) (%0d,%0d,%0d)",
                    i, bus.out_valid, bus.err_mismatch, bus.sync_x, bus.sync_y, bus.dvi_r, bus.dvi_g, bus.dvi_b,
                    ex, ey, i + 1, i + 8, i + 16);
            end
        end
        bus.ready = 1'b0;
        repeat (4) @(negedge clk_25);
        n_vec++;
        if ({bus.outstanding, bus.query_x, bus.query_y} !== {3'd1, 10'd15, 10'd25}) begin
            n_err++; $display("FAIL b2b_refill: got occ=%0d q=(%0d,%0d) want 1 (15,25)", bus.outstanding, bus.query_x, bus.query_y);
        end
        drive_ready(15, 25, 7, 7, 7);
        @(negedge clk_25);
        bus.ready = 1'b0;
        n_vec++;
        if ({bus.out_valid, bus.outstanding} !== {1'b1, 3'd0}) begin
            n_err++; $display("FAIL b2b_drain: got v=%b occ=%0d want 1 0", bus.out_valid, bus.outstanding);
        end
    endtask

    task automatic test_timeout();
        int cyc = 0;
        int extra = 0;
        push_rec(30, 40, 8'h88, 8'h44, 8'hC8);
        while (bus.start !== 1'b1 && cyc < 10) begin @(negedge clk_25); cyc++; end
        n_vec++;
        if (bus.start !== 1'b1) begin n_err++; $display("FAIL timeout_start: no start within %0d cycles", cyc); end
        cyc = 0;
        while (bus.err_timeout !== 1'b1 && cyc < 300) begin @(negedge clk_25); cyc++; end
        n_vec++;
        if (cyc != TO_CYC) begin n_err++; $display("FAIL timeout_latency: got %0d cycles want %0d", cyc, TO_CYC); end
        n_vec++;
        if (bus.outstanding !== 3'd0) begin n_err++; $display("FAIL timeout_pop: got occ=%0d want 0", bus.outstanding); end
        repeat (20) begin
            @(negedge clk_25);
            if (bus.err_timeout === 1'b1) extra++;
        end
        n_vec++;
        if (extra != 0) begin n_err++; $display("FAIL timeout_repeat: got %0d extra pulses want 0", extra); end
    endtask

    task automatic test_spurious();
        drive_ready(1, 2, 1, 1, 1);
        @(negedge clk_25);
        bus.ready = 1'b0;
        n_vec++;
        if ({bus.err_mismatch, bus.out_valid, bus.outstanding} !== {1'b1, 1'b0, 3'd0}) begin
            n_err++; $display("FAIL spurious_flag: got err=%b v=%b occ=%0d want 1 0 0", bus.err_mismatch, bus.out_valid, bus.outstanding);
        end
        n_vec++;
`ifdef SYNC_FALLBACK_EN
        if ({bus.sync_x, bus.sync_y, bus.dvi_r, bus.dvi_g, bus.dvi_b} !== {10'd30, 10'd40, 5'h11, 6'h11, 5'h19}) begin
`else
        if ({bus.sync_x, bus.sync_y, bus.dvi_r, bus.dvi_g, bus.dvi_b} !== {10'd15, 10'd25, 5'd7, 6'd7, 5'd7}) begin
`endif
            n_err++; $display("FAIL spurious_hold: got sync=(%0d,%0d) dvi=(%0d,%0d,%0d)",
                bus.sync_x, bus.sync_y, bus.dvi_r, bus.dvi_g, bus.dvi_b);
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        logic [72:0] all_out;
        for (int i = 0; i < 3; i++) push_rec(50 + i, 60 + i, 8'hF8, 8'hFC, 8'hF8);
        while (bus.outstanding !== 3'd3 && cyc < 20) begin @(negedge clk_25); cyc++; end
        n_vec++;
        if (bus.outstanding !== 3'd3) begin n_err++; $display("FAIL midreset_fill: got occ=%0d want 3", bus.outstanding); end
        rst_n = 1'b0;
        #1;
        all_out = {bus.rdreq, bus.start, bus.query_x, bus.query_y, bus.sync_x, bus.sync_y,
                   bus.dvi_r, bus.dvi_g, bus.dvi_b, bus.out_valid, bus.err_mismatch,
                   bus.err_timeout, bus.outstanding};
        n_vec++;
        if (all_out !== '0) begin n_err++; $display("FAIL midreset_outputs: got %h want 0", all_out); end
        @(negedge clk_25);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_25);
        drive_ready(50, 60, 1, 1, 1);
        @(negedge clk_25);
        bus.ready = 1'b0;
        n_vec++;
        if ({bus.err_mismatch, bus.out_valid, bus.outstanding} !== {1'b1, 1'b0, 3'd0}) begin
            n_err++; $display("FAIL midreset_spurious: got err=%b v=%b occ=%0d want 1 0 0", bus.err_mismatch, bus.out_valid, bus.outstanding);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_mismatch();
        test_back_to_back();
        test_timeout();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
